// File: rtl/bike_position_tracker_pkg.sv
// Shared lightbike constants: screen geometry, sprite size, address width, direction codes.
package bike_position_tracker_pkg;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned SPRITE_SIZE = 30;
  localparam int unsigned ADDR_W      = 19;
  localparam int unsigned X_W         = 10;
  localparam int unsigned Y_W         = 9;
  localparam int unsigned FCNT_W      = 4;
  localparam int unsigned X_MAX       = SCREEN_W - SPRITE_SIZE;
  localparam int unsigned Y_MAX       = SCREEN_H - SPRITE_SIZE;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  // Opposite heading: codes are arranged so that flipping bit 1 reverses.
  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/bike_position_tracker_if.sv
// Control inputs and position outputs of the bike position tracker.
interface bike_position_tracker_if;
  import bike_position_tracker_pkg::*;

  logic              frame_tick;
  logic              enable;
  logic [1:0]        dir_req;
  logic              dir_valid;
  logic [ADDR_W-1:0] startaddr;
  logic [1:0]        direction;
  logic              moved;
  logic              at_edge;

  modport master (
    output frame_tick, enable, dir_req, dir_valid,
    input  startaddr, direction, moved, at_edge
  );

  modport slave (
    input  frame_tick, enable, dir_req, dir_valid,
    output startaddr, direction, moved, at_edge
  );

endinterface

// File: rtl/bike_position_tracker_xy_to_addr.sv
// Linear pixel address y*640+x built from shifts and adds only.
module xy_to_addr
  import bike_position_tracker_pkg::*;
(
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr_c
);

  // y*640 = y*512 + y*128
  assign addr_c = (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7) + ADDR_W'(x);

endmodule

// File: rtl/bike_position_tracker.sv
// Sprite position tracker: frame-paced stepping with direction requests and screen clamping.
module bike_position_tracker
  import bike_position_tracker_pkg::*;
#(
  parameter int unsigned STEP            = 4,
  parameter int unsigned FRAMES_PER_MOVE = 2,
  parameter int unsigned START_X         = 305,
  parameter int unsigned START_Y         = 225
) (
  input logic                    clock,
  input logic                    reset,
  bike_position_tracker_if.slave bus
);

  localparam logic [FCNT_W-1:0] FPM_W      = FCNT_W'(FRAMES_PER_MOVE);
  localparam logic [X_W:0]      STEP_X     = (X_W + 1)'(STEP);
  localparam logic [Y_W:0]      STEP_Y     = (Y_W + 1)'(STEP);
  localparam logic [X_W-1:0]    X_LIM      = X_W'(X_MAX);
  localparam logic [Y_W-1:0]    Y_LIM      = Y_W'(Y_MAX);
  localparam logic [X_W-1:0]    X_START    = X_W'(START_X);
  localparam logic [Y_W-1:0]    Y_START    = Y_W'(START_Y);
  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_Y * SCREEN_W + START_X);

  logic [FCNT_W-1:0] cnt_q, cnt_next;
  dir_t              pend_q, pend_next, dir_cur, dir_next, eff_dir;
  logic [X_W-1:0]    x_q, x_next;
  logic [Y_W-1:0]    y_q, y_next;
  logic [X_W:0]      x_sum;
  logic [Y_W:0]      y_sum;
  logic              moved_next, edge_next, event_c, blocked;
  logic [ADDR_W-1:0] addr_next_c;

  assign dir_cur = dir_t'(bus.direction);
  assign x_sum   = {1'b0, x_q} + STEP_X;
  assign y_sum   = {1'b0, y_q} + STEP_Y;

  // Address of the position about to be registered, so startaddr tracks x/y exactly.
  xy_to_addr u_addr (
    .x      (x_next),
    .y      (y_next),
    .addr_c (addr_next_c)
  );

  // Next-state: request filtering, frame pacing, clamped stepping.
  always_comb begin
    cnt_next   = cnt_q;
    dir_next   = dir_cur;
    x_next     = x_q;
    y_next     = y_q;
    moved_next = 1'b0;
    edge_next  = bus.at_edge;
    event_c    = 1'b0;
    blocked    = 1'b0;
    eff_dir    = pend_q;

    // Reversals are judged against the committed heading, not the pending one.
    if (bus.dir_valid && (dir_t'(bus.dir_req) != reverse_dir(dir_cur))) begin
      eff_dir = dir_t'(bus.dir_req);
    end
    pend_next = eff_dir;

    if (bus.enable && bus.frame_tick) begin
      if (cnt_q + FCNT_W'(1) == FPM_W) begin
        cnt_next = '0;
        event_c  = 1'b1;
      end else begin
        cnt_next = cnt_q + FCNT_W'(1);
      end
    end

    if (event_c) begin
      dir_next = eff_dir;
      case (eff_dir)
        DIR_UP: begin
          if (y_q == '0) blocked = 1'b1;
          else y_next = ({1'b0, y_q} < STEP_Y) ? '0 : y_q - STEP_Y[Y_W-1:0];
        end
        DIR_RIGHT: begin
          if (x_q == X_LIM) blocked = 1'b1;
          else x_next = (x_sum > {1'b0, X_LIM}) ? X_LIM : x_sum[X_W-1:0];
        end
        DIR_DOWN: begin
          if (y_q == Y_LIM) blocked = 1'b1;
          else y_next = (y_sum > {1'b0, Y_LIM}) ? Y_LIM : y_sum[Y_W-1:0];
        end
        default: begin
          if (x_q == '0) blocked = 1'b1;
          else x_next = ({1'b0, x_q} < STEP_X) ? '0 : x_q - STEP_X[X_W-1:0];
        end
      endcase
      moved_next = ~blocked;
      edge_next  = blocked;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      pend_q        <= DIR_RIGHT;
      x_q           <= X_START;
      y_q           <= Y_START;
      bus.startaddr <= START_ADDR;
      bus.direction <= DIR_RIGHT;
      bus.moved     <= 1'b0;
      bus.at_edge   <= 1'b0;
    end else begin
      cnt_q         <= cnt_next;
      pend_q        <= pend_next;
      x_q           <= x_next;
      y_q           <= y_next;
      bus.startaddr <= addr_next_c;
      bus.direction <= dir_next;
      bus.moved     <= moved_next;
      bus.at_edge   <= edge_next;
    end
  end

endmodule

// File: tb/tb_bike_position_tracker.sv
// Bench for bike_position_tracker: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a coordinate-level model.
module tb_bike_position_tracker;

  localparam int STEP  = 4;
  localparam int FPM   = 2;
  localparam int XMAX  = 610;
  localparam int YMAX  = 450;
  localparam int RST_A = 144305;

  logic clock = 1'b0;
  logic reset;
  bike_position_tracker_if bus ();

  bike_position_tracker dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Model state: plain coordinates and heading codes.
  int mx, my, mdir, mpend, mcnt, nx, ny;
  bit mmoved, medge, mev;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference model advanced on the same edges as the design.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mx = 305; my = 225; mdir = 1; mpend = 1; mcnt = 0; mmoved = 0; medge = 0;
    end else begin
      mmoved = 0;
      mev    = 0;
      if (bus.dir_valid && int'(bus.dir_req) != (mdir + 2) % 4) mpend = int'(bus.dir_req);
      if (bus.enable && bus.frame_tick) begin
        mcnt++;
        if (mcnt == FPM) begin
          mcnt = 0;
          mev  = 1;
        end
      end
      if (mev) begin
        mdir = mpend;
        nx = clamp(mx + ((mdir == 1) ? STEP : (mdir == 3) ? -STEP : 0), XMAX);
        ny = clamp(my + ((mdir == 2) ? STEP : (mdir == 0) ? -STEP : 0), YMAX);
        if (nx == mx && ny == my) begin
          medge = 1;
        end else begin
          mx = nx; my = ny; mmoved = 1; medge = 0;
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("startaddr", int'(bus.startaddr), my * 640 + mx);
      chk("direction", int'(bus.direction), mdir);
      chk("moved", int'(bus.moved), int'(mmoved));
      chk("at_edge", int'(bus.at_edge), int'(medge));
    end
  end

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic frame();
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
  endtask

  task automatic req(input int d);
    bus.dir_req   = 2'(d);
    bus.dir_valid = 1'b1;
    cyc();
    bus.dir_valid = 1'b0;
  endtask

  int bias;

  initial begin
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.enable     = 1'b0;
    bus.dir_req    = 2'd0;
    bus.dir_valid  = 1'b0;
    cyc();
    cyc();
    chk_en = 1'b1;

    // Reset values, then first move after two ticks.
    do_reset();
    chk("rst_addr", int'(bus.startaddr), RST_A);
    chk("rst_dir", int'(bus.direction), 1);
    chk("rst_moved", int'(bus.moved), 0);
    chk("rst_edge", int'(bus.at_edge), 0);
    bus.enable = 1'b1;
    frame();
    chk("tick1_moved", int'(bus.moved), 0);
    frame();
    chk("tick2_moved", int'(bus.moved), 1);
    chk("tick2_addr", int'(bus.startaddr), 144309);
    cyc();
    chk("moved_pulse", int'(bus.moved), 0);

    // Reverse request ignored.
    do_reset();
    req(3);
    frame();
    frame();
    chk("rev_dir", int'(bus.direction), 1);
    chk("rev_addr", int'(bus.startaddr), 144309);

    // Last request wins.
    do_reset();
    req(0);
    req(2);
    frame();
    frame();
    chk("lastwin_dir", int'(bus.direction), 2);
    chk("lastwin_addr", int'(bus.startaddr), RST_A + 2560);

    // Frozen while disabled; pending direction still captured.
    do_reset();
    bus.enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        bus.dir_req   = 2'd0;
        bus.dir_valid = 1'b1;
      end
      frame();
      bus.dir_valid = 1'b0;
    end
    chk("frozen_addr", int'(bus.startaddr), RST_A);
    chk("frozen_dir", int'(bus.direction), 1);
    bus.enable = 1'b1;
    frame();
    frame();
    chk("thaw_dir", int'(bus.direction), 0);
    chk("thaw_addr", int'(bus.startaddr), RST_A - 2560);

    // Reset between the two ticks restarts the frame count.
    do_reset();
    frame();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst_addr", int'(bus.startaddr), RST_A);
    cyc();
    frame();
    chk("midrst_t1", int'(bus.moved), 0);
    frame();
    chk("midrst_t2", int'(bus.moved), 1);

    // Right edge: 305 -> 609 in 76 steps, saturate to 610, then blocked.
    do_reset();
    for (int i = 0; i < 77; i++) begin
      frame();
      frame();
      if (i == 75) chk("edge_609", int'(bus.startaddr), 144609);
      if (i == 76) begin
        chk("edge_610", int'(bus.startaddr), 144610);
        chk("edge_610_moved", int'(bus.moved), 1);
      end
    end
    frame();
    frame();
    chk("blocked_moved", int'(bus.moved), 0);
    chk("blocked_edge", int'(bus.at_edge), 1);
    chk("blocked_addr", int'(bus.startaddr), 144610);
    req(0);
    frame();
    frame();
    chk("unblock_edge", int'(bus.at_edge), 0);
    chk("unblock_addr", int'(bus.startaddr), 144610 - 2560);

    // Randomized traffic with a drifting preferred heading so the edges get hit.
    bias = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) bias = int'($urandom_range(0, 3));
      bus.enable     = ($urandom_range(0, 9) != 0);
      bus.frame_tick = ($urandom_range(0, 2) == 0);
      bus.dir_valid  = ($urandom_range(0, 3) == 0);
      bus.dir_req    = ($urandom_range(0, 9) < 7) ? 2'(bias) : 2'($urandom_range(0, 3));
      reset          = ($urandom_range(0, 699) == 0);
      cyc();
    end
    reset          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.dir_valid  = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
